// File: rtl/shiftscale_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shiftscale_ctrl
//  Purpose  : Raster-scans a square image, computes centre-minus-neighbour
//             operands for a shift-scale datapath and writes its results back.
//  Revision : 1.0  initial release
// ============================================================================
module shiftscale_ctrl #(
    parameter int  IMG_LOG2 = 4,
    localparam int AW       = 2 * IMG_LOG2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          ss_en,
    output logic [8:0]    ss_i1,
    output logic [8:0]    ss_i2,
    output logic [8:0]    ss_i3,
    output logic [8:0]    ss_i4,
    output logic [8:0]    ss_i5,
    input  logic [7:0]    ss_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LAST   = 3'd2,
        ISSUE  = 3'd3,
        WRITE  = 3'd4,
        BORDER = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [IMG_LOG2-1:0] C_COORD_MAX = '1;
    localparam logic [IMG_LOG2-1:0] C_ONE       = IMG_LOG2'(1);
    localparam logic [2:0]          C_PH_LAST   = 3'd4;

    state_t              state_q, state_d;
    logic [IMG_LOG2-1:0] x_q, x_d;
    logic [IMG_LOG2-1:0] y_q, y_d;
    logic [2:0]          phase_q, phase_d;
    logic [7:0]          c_q, c_d;
    logic [7:0]          n_q, n_d;
    logic [7:0]          s_q, s_d;
    logic [7:0]          w_q, w_d;
    logic [8:0]          ss_i1_q, ss_i1_d;
    logic [8:0]          ss_i2_q, ss_i2_d;
    logic [8:0]          ss_i3_q, ss_i3_d;
    logic [8:0]          ss_i4_q, ss_i4_d;
    logic [8:0]          ss_i5_q, ss_i5_d;

    logic                last_pix;
    logic [IMG_LOG2-1:0] nx;
    logic [IMG_LOG2-1:0] ny;
    logic                next_border;

    always_comb begin
        last_pix    = (x_q == C_COORD_MAX) && (y_q == C_COORD_MAX);
        nx          = (x_q == C_COORD_MAX) ? '0 : (x_q + C_ONE);
        ny          = (x_q == C_COORD_MAX) ? (y_q + C_ONE) : y_q;
        next_border = (nx == '0) || (nx == C_COORD_MAX) ||
                      (ny == '0) || (ny == C_COORD_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            phase_q <= '0;
            c_q     <= '0;
            n_q     <= '0;
            s_q     <= '0;
            w_q     <= '0;
            ss_i1_q <= '0;
            ss_i2_q <= '0;
            ss_i3_q <= '0;
            ss_i4_q <= '0;
            ss_i5_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            phase_q <= phase_d;
            c_q     <= c_d;
            n_q     <= n_d;
            s_q     <= s_d;
            w_q     <= w_d;
            ss_i1_q <= ss_i1_d;
            ss_i2_q <= ss_i2_d;
            ss_i3_q <= ss_i3_d;
            ss_i4_q <= ss_i4_d;
            ss_i5_q <= ss_i5_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        phase_d = phase_q;
        c_d     = c_q;
        n_d     = n_q;
        s_d     = s_q;
        w_d     = w_q;
        ss_i1_d = ss_i1_q;
        ss_i2_d = ss_i2_q;
        ss_i3_d = ss_i3_q;
        ss_i4_d = ss_i4_q;
        ss_i5_d = ss_i5_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Pixel (0,0) is always on the border.
                    state_d = BORDER;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = '0;
                end
            end
            FETCH: begin
                // Read data arrives one cycle behind its address.
                unique case (phase_q)
                    3'd1:    c_d = rd_data;
                    3'd2:    n_d = rd_data;
                    3'd3:    s_d = rd_data;
                    3'd4:    w_d = rd_data;
                    default: ;
                endcase
                phase_d = phase_q + 3'd1;
                if (phase_q == C_PH_LAST) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                ss_i1_d = {1'b0, c_q} - {1'b0, n_q};
                ss_i2_d = {1'b0, c_q} - {1'b0, s_q};
                ss_i3_d = {1'b0, c_q} - {1'b0, w_q};
                ss_i4_d = {1'b0, c_q} - {1'b0, rd_data};
                ss_i5_d = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WRITE;
            end
            WRITE, BORDER: begin
                phase_d = '0;
                if (last_pix) begin
                    state_d = DONE;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    x_d     = nx;
                    y_d     = ny;
                    state_d = next_border ? BORDER : FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        rd_en   = (state_q == FETCH);
        ss_en   = (state_q == ISSUE);
        wr_en   = (state_q == WRITE) || (state_q == BORDER);
        wr_addr = {y_q, x_q};
        wr_data = (state_q == WRITE) ? ss_o : 8'h00;
        rd_addr = '0;
        if (state_q == FETCH) begin
            unique case (phase_q)
                3'd0:    rd_addr = {y_q, x_q};
                3'd1:    rd_addr = {y_q - C_ONE, x_q};
                3'd2:    rd_addr = {y_q + C_ONE, x_q};
                3'd3:    rd_addr = {y_q, x_q - C_ONE};
                3'd4:    rd_addr = {y_q, x_q + C_ONE};
                default: rd_addr = '0;
            endcase
        end
    end

    assign ss_i1 = ss_i1_q;
    assign ss_i2 = ss_i2_q;
    assign ss_i3 = ss_i3_q;
    assign ss_i4 = ss_i4_q;
    assign ss_i5 = ss_i5_q;

endmodule
`default_nettype wire

// File: doc/shiftscale_ctrl.md
SHIFTSCALE_CTRL -- requirements
Module: shiftscale_ctrl

Interface
REQ-001 Parameter: IMG_LOG2, default 4, log2 of square image side (16x16 image); address width AW = 2*IMG_LOG2.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 start  input  1  pulse requesting one full-image pass.
REQ-005 busy  output  1  high while a pass is in progress.
REQ-006 done  output  1  one-cycle pulse at pass completion.
REQ-007 rd_en  output  1  source-RAM read strobe.
REQ-008 rd_addr  output  AW  source pixel address, y*side+x.
REQ-009 rd_data  input  8  unsigned source pixel, valid the cycle after rd_en.
REQ-010 wr_en  output  1  destination-RAM write strobe.
REQ-011 wr_addr  output  AW  destination pixel address.
REQ-012 wr_data  output  8  result pixel.
REQ-013 ss_en  output  1  enable to the shift-scale datapath.
REQ-014 ss_i1..ss_i5  output  9 each  signed operands to the datapath.
REQ-015 ss_o  input  8  datapath result, registered on the clk edge where ss_en=1, valid the following cycle.

Function
REQ-016 States SHALL be IDLE, FETCH, LAST, ISSUE, WRITE, BORDER, DONE.
REQ-017 IDLE: start=1 -> pixel (0,0) processing begins next cycle; start SHALL be ignored in every other state.
REQ-018 Pixels SHALL be processed in raster order, x fastest, each destination address written exactly once, strictly increasing.
REQ-019 Border pixel (x or y = 0 or side-1): one BORDER cycle, wr_en=1, wr_data=0, no reads, ss_en=0.
REQ-020 Interior pixel: FETCH 5 cycles, rd_en=1, rd_addr in order C(x,y), N(x,y-1), S(x,y+1), W(x-1,y), E(x+1,y); LAST 1 cycle captures E data; ISSUE 1 cycle ss_en=1; WRITE 1 cycle wr_en=1, wr_data=ss_o; total 8 cycles.
REQ-021 Operands: pixels zero-extended to 9 bits; ss_i1=C-N, ss_i2=C-S, ss_i3=C-W, ss_i4=C-E (9-bit two's complement, range -255..+255, no saturation); ss_i5=0.
REQ-022 ss_i1..ss_i5 SHALL be registered and stable during ISSUE; outside ISSUE their value is don't-care but ss_en SHALL be 0.
REQ-023 After the last pixel's write, DONE SHALL last one cycle with done=1, then IDLE.
REQ-024 busy SHALL be 1 from the cycle after start is accepted through the DONE cycle inclusive, 0 otherwise.
REQ-025 Pass latency, default size: start sampled in cycle 0, done=1 in cycle 1629 (196*8 + 60*1 = 1628 processing cycles).
REQ-026 rd_en, wr_en, ss_en, done SHALL never be asserted in IDLE; at most one of rd_en/wr_en high per cycle.
REQ-027 Pixel coordinate counters SHALL wrap to 0 only on DONE entry; no write beyond address side*side-1.

Reset
REQ-028 rst=0 at a clk edge SHALL force IDLE, clear counters, and drive busy, done, rd_en, wr_en, ss_en to 0 and rd_addr, wr_addr, wr_data, ss_i1..ss_i5 to 0 from the next cycle.
REQ-029 Reset mid-pass SHALL abandon the pass with no further write; a later start SHALL run a complete fresh pass from pixel (0,0).

Verification
REQ-030 Reset: rst=0 for 2 cycles, start=1 held -> all outputs 0, busy=0, no strobes.
REQ-031 Flat image, all pixels 100 -> interior ISSUE operands all 0; border writes 0; 256 writes, addresses 0..255 in order; done in cycle 1629.
REQ-032 Single pixel (5,5)=200, rest 0 -> at (5,5) ss_i1..i4=+200, ss_i5=0; at (5,4) ss_i2=-200 (9'h138); at (4,5) ss_i4=-200.
REQ-033 Extremes: C=255, N=S=W=E=0 -> operands +255; C=0, neighbours 255 -> operands -255 (9'h101).
REQ-034 start pulsed during FETCH and during DONE -> ignored; exactly one pass, one done pulse.
REQ-035 rst=0 in cycle 500 of a pass -> no wr_en after reset, busy=0; next start completes all 256 writes and done in cycle 1629 relative to that start.
